uart_tx_frame: RTL and testbench

Parametrised UART transmitter that serialises one character per valid/ready handshake onto a single `tx` line. Data width, stop-bit count and baud divisor are set at elaboration, and optional parity is a compile-time feature. Every bit lasts exactly `BAUD_DIV` clocks, and back-to-back characters are sent with no idle gap. It sits between a byte producer (command/response logic or a FIFO) and the FPGA pin driving the PC link.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_frame.sv | 152 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity-mode encodings and the baud
// divisor helper. The transmitter and the future receiver both use this package.
package uart_pkg;

   // Frame state machine states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Encodings of parity_mode; 2'b11 is treated as none
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Clocks per bit, truncated toward zero
   function automatic int calc_baud_div(input int clock_freq, input int baudrate);
      return clock_freq / baudrate;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: free-running 0..BAUD_DIV-1 counter with a synchronous
// restart. tick is high in the last clock of every bit period, so a consumer
// that advances on tick changes its output exactly at the bit boundary.
module uart_baud_tick #(
   parameter int BAUD_DIV = 4
) (
   input  logic clock,
   input  logic n_reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(BAUD_DIV - 1));

   // Bit-period counter; restart realigns the period to a fresh accept
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset)
         cnt <= '0;
      else if (restart || tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one character per valid/ready handshake, LSB first,
// start bit, DATA_BITS data bits, optional parity, STOP_BITS stop bits.
// Compile-time option: define UART_TX_PARITY_EN to build in the parity bit
// and honour parity_mode; otherwise parity_mode is ignored.
// tx and tx_busy are registered; tx_ready/tx_done are decoded from registered
// state and the baud counter only, so there is no path from tx_valid to them.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 27000000,
   parameter int BAUDRATE   = 115200,
   parameter int BAUD_DIV   = calc_baud_div(CLOCK_FREQ, BAUDRATE),
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clock,
   input  logic                 n_reset,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic [1:0]           parity_mode,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   if (BAUD_DIV < 2) begin : g_bad_baud_div
      $error("uart_tx_frame: BAUD_DIV must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   localparam int BCW = $clog2(DATA_BITS + 1);

   uart_state_e          state;
   logic [DATA_BITS-1:0] shreg;
   logic [BCW-1:0]       bit_cnt;
   logic                 stop_cnt;
   logic                 tick;
   logic                 last_stop;
   logic                 accept;

`ifdef UART_TX_PARITY_EN
   logic par_en;
   logic par_bit;
`else
   logic unused_parity_mode;
   assign unused_parity_mode = ^parity_mode;
`endif

   assign last_stop = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1)) && tick;
   assign tx_ready  = (state == IDLE) || last_stop;
   assign tx_done   = last_stop;
   assign accept    = tx_valid && tx_ready;

   uart_baud_tick #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clock   (clock),
      .n_reset (n_reset),
      .restart (accept),
      .tick    (tick)
   );

   // Frame FSM: advances on baud ticks; an accept (IDLE or final stop clock)
   // overrides the case result and launches the next start bit
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
            end
            START: if (tick) begin
               state   <= DATA;
               tx      <= shreg[0];
               bit_cnt <= '0;
            end
            DATA: if (tick) begin
               if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  if (par_en) begin
                     state <= PARITY;
                     tx    <= par_bit;
                  end else begin
                     state    <= STOP;
                     tx       <= 1'b1;
                     stop_cnt <= 1'b0;
                  end
`else
                  state    <= STOP;
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
`endif
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
                  shreg   <= shreg >> 1;
                  tx      <= shreg[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
               state    <= STOP;
               tx       <= 1'b1;
               stop_cnt <= 1'b0;
            end
`endif
            STOP: if (tick) begin
               if (last_stop) begin
                  state   <= IDLE;
                  tx      <= 1'b1;
                  tx_busy <= 1'b0;
               end else begin
                  stop_cnt <= stop_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               tx      <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase

         if (accept) begin
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            shreg   <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_en  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_bit <= (^tx_data) ^ (parity_mode == PAR_ODD);
`endif
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: BAUD_DIV=4, 8N1 instance plus a 7-bit,
// 2-stop instance. Parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif
   localparam int BD = 4;

   logic       clock = 1'b0;
   logic       n_reset = 1'b0;

   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic [1:0] parity_mode = '0;
   logic       tx_ready, tx, tx_busy, tx_done;

   logic       tx_valid2 = 1'b0;
   logic [6:0] tx_data2 = '0;
   logic       tx_ready2, tx2, tx_busy2, tx_done2;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   uart_tx_frame #(.BAUD_DIV(BD), .DATA_BITS(8), .STOP_BITS(1)) dut (
      .clock(clock), .n_reset(n_reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .parity_mode(parity_mode), .tx(tx), .tx_busy(tx_busy),
      .tx_done(tx_done)
   );

   uart_tx_frame #(.BAUD_DIV(BD), .DATA_BITS(7), .STOP_BITS(2)) dut2 (
      .clock(clock), .n_reset(n_reset), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
      .tx_data(tx_data2), .parity_mode(2'b00), .tx(tx2), .tx_busy(tx_busy2),
      .tx_done(tx_done2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a character and hold until it is accepted (bounded wait)
   task automatic send(input bit sel, input logic [8:0] d, input logic [1:0] m, input bit hold);
      int guard = 0;
      if (sel) begin tx_valid2 = 1'b1; tx_data2 = d[6:0]; end
      else begin tx_valid = 1'b1; tx_data = d[7:0]; parity_mode = m; end
      while (!(sel ? tx_ready2 : tx_ready) && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 200) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1;
      if (!hold) begin
         if (sel) tx_valid2 = 1'b0; else tx_valid = 1'b0;
      end
   endtask

   // Walk one frame clock by clock, starting in the clock after the accept
   task automatic check_frame(input string tag, input bit sel, input logic [8:0] d,
                              input int db, input bit par, input bit pbit, input int sb);
      int len = (1 + db + (par ? 1 : 0) + sb) * BD;
      for (int i = 1; i <= len; i++) begin
         int  k;
         bit  e;
         @(negedge clock);
         k = (i - 1) / BD;
         if (k == 0)                  e = 1'b0;
         else if (k <= db)            e = d[k-1];
         else if (par && k == db + 1) e = pbit;
         else                         e = 1'b1;
         chk($sformatf("%s_tx%0d", tag, i), sel ? tx2 : tx, e);
         chk($sformatf("%s_busy%0d", tag, i), sel ? tx_busy2 : tx_busy, 1'b1);
         chk($sformatf("%s_done%0d", tag, i), sel ? tx_done2 : tx_done, (i == len));
         chk($sformatf("%s_rdy%0d", tag, i), sel ? tx_ready2 : tx_ready, (i == len));
      end
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         chk({tag, "_tx"}, tx, 1'b1);
         chk({tag, "_busy"}, tx_busy, 1'b0);
         chk({tag, "_rdy"}, tx_ready, 1'b1);
      end
   endtask

   initial begin
      bit pa;
      // Reset held 3 clocks
      repeat (3) @(posedge clock);
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_rdy", tx_ready, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      chk("rst_tx2", tx2, 1'b1);
      @(negedge clock);
      n_reset = 1'b1;
      check_idle("idle0", 4);

      // 0xA5, no parity
      send(1'b0, 9'h0A5, 2'b00, 1'b0);
      check_frame("a5", 1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1);
      @(posedge clock);
      check_idle("idle1", 6);

      // 0x03 even / odd parity (parity bit present only when built in)
      send(1'b0, 9'h003, 2'b01, 1'b0);
      check_frame("even", 1'b0, 9'h003, 8, PAR_BUILT, 1'b0, 1);
      @(posedge clock);
      check_idle("idle2", 2);
      send(1'b0, 9'h003, 2'b10, 1'b0);
      check_frame("odd", 1'b0, 9'h003, 8, PAR_BUILT, 1'b1, 1);
      @(posedge clock);
      check_idle("idle3", 2);

      // Mode 11 behaves as none
      send(1'b0, 9'h0C4, 2'b11, 1'b0);
      check_frame("m11", 1'b0, 9'h0C4, 8, 1'b0, 1'b0, 1);
      @(posedge clock);
      check_idle("idle4", 2);

      // Back-to-back 0x55 then 0xAA with valid held high
      send(1'b0, 9'h055, 2'b00, 1'b1);
      tx_data = 8'hAA;
      check_frame("b2b0", 1'b0, 9'h055, 8, 1'b0, 1'b0, 1);
      @(posedge clock);
      #1 tx_valid = 1'b0;
      check_frame("b2b1", 1'b0, 9'h0AA, 8, 1'b0, 1'b0, 1);
      @(posedge clock);
      check_idle("idle5", 2);

      // tx_data toggled every clock mid-frame; odd parity of latched 0x3C
      send(1'b0, 9'h03C, 2'b10, 1'b0);
      pa = PAR_BUILT;
      fork
         check_frame("tog", 1'b0, 9'h03C, 8, pa, 1'b1, 1);
         begin
            for (int i = 0; i < 40; i++) begin
               tx_data = ~tx_data;
               @(posedge clock);
               #1;
            end
         end
      join
      @(posedge clock);
      check_idle("idle6", 2);

      // 7 data bits, 2 stop bits
      send(1'b1, 9'h07F, 2'b00, 1'b0);
      check_frame("d7s2", 1'b1, 9'h07F, 7, 1'b0, 1'b0, 2);
      send(1'b1, 9'h052, 2'b00, 1'b0);
      check_frame("d7s2b", 1'b1, 9'h052, 7, 1'b0, 1'b0, 2);

      // Asynchronous reset mid-frame
      send(1'b0, 9'h000, 2'b00, 1'b0);
      repeat (10) @(negedge clock);
      chk("pre_rst_tx", tx, 1'b0);
      #2 n_reset = 1'b0;
      #1;
      chk("arst_tx", tx, 1'b1);
      chk("arst_busy", tx_busy, 1'b0);
      chk("arst_rdy", tx_ready, 1'b1);
      @(negedge clock);
      n_reset = 1'b1;
      send(1'b0, 9'h0E1, 2'b00, 1'b0);
      check_frame("post_rst", 1'b0, 9'h0E1, 8, 1'b0, 1'b0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
